arb_rr8: RTL
============

# arb_rr8

Round-robin arbiter that shares one resource among 8 requesters. It produces a registered one-hot grant and its 3-bit binary index; the index matches what the 8-to-3 encoder produces for the same one-hot value. Each grant is held until the owner releases it, the owner drops its request, or a hold limit expires. The block sits in front of any shared datapath resource (bus, register port, ALU) where fair, starvation-free access is required.

## Interface
- MAX_HOLD, 15, maximum consecutive grant cycles per tenure; 0 disables the limit; legal range 0..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- release  input  1  current owner ends its tenure; ignored when no grant is active.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_idx  output  3  binary index of the set bit of gnt; 3'b000 when gnt is zero.
- gnt_valid  output  1  high exactly when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a tenure is ended by MAX_HOLD.

## Operation
- Reset (rst_n=0 at a clk edge) takes priority over everything. After that edge: gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state IDLE, pointer ptr=0, hold counter=0.
- Internal state: FSM {IDLE, BUSY}, ptr[2:0] (highest-priority requester for the next arbitration), hold counter (8 bits).
- IDLE: if req≠0, pick the first set bit of req searching ptr, ptr+1, …, wrapping 7→0.
  - Register the winner into gnt, gnt_idx and gnt_valid=1.
  - Load hold counter=1 and go to BUSY.
  - If req=0, stay in IDLE with outputs zero.
- BUSY: the tenure ends at the current edge if any of the following hold:
  - (a) release=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD≠0 and hold counter==MAX_HOLD.
- On tenure end:
  - gnt=0, gnt_valid=0, gnt_idx=0;
  - ptr=gnt_idx+1 mod 8 (index 7 gives ptr 0);
  - go to IDLE;
  - timeout=1 for the next cycle only if (c) alone caused the end.
- Otherwise the block stays in BUSY, the grant is unchanged and the hold counter increments. Requests from other requesters never preempt the current owner.
- Priority of simultaneous end causes: (a) or (b) together with (c) counts as a normal release, so timeout stays 0.
- The pointer advances only at tenure end, never on reset or while IDLE.
- gnt is always exactly one-hot or zero. gnt_idx never carries X/Z.

## Timing
- Grant latency: req sampled at edge N in IDLE, gnt visible after edge N (1 cycle).
- Release latency: release/req drop sampled at edge N, gnt=0 after edge N.
- Mandatory one idle (gnt=0) cycle between consecutive tenures (bus turnaround). Back-to-back arbitration therefore costs tenure length + 1 cycle.
- Maximum tenure with limit enabled: exactly MAX_HOLD cycles of gnt_valid=1.
- Worst-case wait for a continuously requesting input: 7·(MAX_HOLD+1) cycles after its request is first sampled, plus its own 1-cycle grant latency.
- timeout is high only during the idle cycle that follows the forced end.
- Reset mid-tenure: grant drops after the reset edge and ptr returns to 0. No timeout pulse.

## Test plan
- Reset: rst_n=0, req=8'hFF for 2 edges -> gnt=0, gnt_idx=0, gnt_valid=0, timeout=0. Release reset -> gnt=8'b00000001, gnt_idx=000 one cycle later.
- Single request: req=8'b00000100 from IDLE -> next cycle gnt=8'b00000100, gnt_idx=010, gnt_valid=1. Pulse release for 1 cycle -> gnt=0 after that edge, next arbitration starts from ptr=3.
- Fairness: req=8'hFF held, release pulsed on every grant cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with one gnt=0 cycle between each pair.
- Hold limit: MAX_HOLD=4, req=8'b00010000 held, release=0 -> gnt_valid high exactly 4 cycles, then 1 cycle with gnt=0 and timeout=1, then re-grant of index 4 (search wraps 5..7,0..4).
- Wrap and implicit release: after a tenure of index 6 ends (ptr=7), req=8'b01000001 -> grant index 0. Owner drops req[0] -> gnt=0 next cycle, timeout=0. Same cycle release=1 with the counter at MAX_HOLD -> timeout=0.
- Reset mid-tenure: index 5 granted, rst_n=0 one edge -> all outputs 0. req=8'b00100001 afterward -> grant index 0 (ptr reset).

Source files
------------

// File: rtl/arb_rr8.sv
// arb_rr8: eight-way round-robin arbiter with registered one-hot grant, binary index
// and an optional per-tenure hold limit that forces a bus-turnaround idle cycle.

module arb_rr8 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       owner_release,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic       LIMIT_EN   = (MAX_HOLD != 0);

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] hold_cnt_r, hold_cnt_s;
  logic [7:0] gnt_r, gnt_s;
  logic [2:0] gnt_idx_r, gnt_idx_s;
  logic       gnt_valid_r, gnt_valid_s;
  logic       timeout_r, timeout_s;
  logic [3:0] pick_s;
  logic       end_normal_s;
  logic       end_limit_s;

  // Returns {found, index} of the first set request searching base, base+1, ... wrapping.
  function automatic logic [3:0] rr_pick(input logic [7:0] req_v, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] cand;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      cand = base + 3'(i);
      if (req_v[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Decodes a binary index into the one-hot grant so both outputs always agree.
  function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  // Arbitration search, tenure-end causes and next-state/output computation.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    hold_cnt_s   = hold_cnt_r;
    gnt_s        = gnt_r;
    gnt_idx_s    = gnt_idx_r;
    gnt_valid_s  = gnt_valid_r;
    timeout_s    = 1'b0;
    pick_s       = rr_pick(req, ptr_r);
    end_normal_s = owner_release | ~req[gnt_idx_r];
    end_limit_s  = LIMIT_EN && (hold_cnt_r == HOLD_LIMIT);
    case (state_r)
      ST_IDLE: begin
        if (pick_s[3]) begin
          gnt_s       = idx_to_onehot(pick_s[2:0]);
          gnt_idx_s   = pick_s[2:0];
          gnt_valid_s = 1'b1;
          hold_cnt_s  = 8'd1;
          state_s     = ST_BUSY;
        end else begin
          gnt_s       = 8'h00;
          gnt_idx_s   = 3'd0;
          gnt_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (end_normal_s || end_limit_s) begin
          gnt_s       = 8'h00;
          gnt_idx_s   = 3'd0;
          gnt_valid_s = 1'b0;
          hold_cnt_s  = 8'd0;
          ptr_s       = gnt_idx_r + 3'd1;
          // A limit hit coinciding with a normal release is reported as a release.
          timeout_s   = end_limit_s & ~end_normal_s;
          state_s     = ST_IDLE;
        end else begin
          hold_cnt_s  = hold_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = 8'h00;
        gnt_idx_s   = 3'd0;
        gnt_valid_s = 1'b0;
        hold_cnt_s  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd0;
      hold_cnt_r  <= 8'd0;
      gnt_r       <= 8'h00;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      hold_cnt_r  <= hold_cnt_s;
      gnt_r       <= gnt_s;
      gnt_idx_r   <= gnt_idx_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_idx   = gnt_idx_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

  arb_rr8_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt_r),
    .gnt_idx   (gnt_idx_r),
    .gnt_valid (gnt_valid_r),
    .timeout   (timeout_r)
  );

endmodule

// Output consistency checks for arb_rr8; no logic of its own.
module arb_rr8_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [7:0] gnt,
  input logic [2:0] gnt_idx,
  input logic       gnt_valid,
  input logic       timeout
);

  // Grant encoding invariants sampled every cycle outside reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_onehot0: assert ($onehot0(gnt)) else $error("arb_rr8: gnt not one-hot0");
      a_valid:   assert (gnt_valid == (gnt != 8'h00)) else $error("arb_rr8: gnt_valid mismatch");
      a_idx:     assert (gnt == (gnt_valid ? (8'b0000_0001 << gnt_idx) : 8'h00))
                   else $error("arb_rr8: gnt_idx mismatch");
      a_tmo:     assert (!(timeout && gnt_valid)) else $error("arb_rr8: timeout during grant");
    end
  end

endmodule
